sync_ram_pipe: RTL and testbench

SYNC_RAM_PIPE -- requirements
Module: sync_ram_pipe

---
 rtl/sync_ram_pipe.sv | 151 +++++++++++++++
 tb/tb_sync_ram_pipe.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_ram_pipe.sv
// Single-clock RAM with a registered request stage, per-byte writes and an optional output register.
// With CLR_ON_RST the array is zeroed word by word after reset before any request is accepted.
module sync_ram_pipe #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 10,
  parameter int OUT_REG    = 0,
  parameter int WR_MODE    = 0,
  parameter int CLR_ON_RST = 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                en,
  input  logic [DATA_W/8-1:0] wen,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic                ready,
  output logic                rvalid,
  output logic [DATA_W-1:0]   rdata
);
  localparam int NB = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic {INIT, RUN} state_e;
  localparam state_e RST_STATE = (CLR_ON_RST != 0) ? INIT : RUN;

  generate
    if ((DATA_W % 8) != 0 || DATA_W < 8) begin : g_bad_width
      $error("sync_ram_pipe: DATA_W must be a positive multiple of 8");
    end
  endgenerate

  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_w,
                                                    input logic [DATA_W-1:0] new_w,
                                                    input logic [NB-1:0]     be);
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int b = 0; b < NB; b++) begin
      if (be[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return res;
  endfunction

  state_e              state_q, state_d;
  logic [ADDR_W:0]     init_cnt_q, init_cnt_d;
  logic                ready_q, ready_d;
  logic                accept;

  logic                vld_p0_q, vld_p0_d;
  logic [NB-1:0]       wen_p0_q, wen_p0_d;
  logic [ADDR_W-1:0]   addr_p0_q, addr_p0_d;
  logic [DATA_W-1:0]   wdata_p0_q, wdata_p0_d;

  logic                vld_p1_q, vld_p1_d;
  logic [DATA_W-1:0]   rdata_p1_q, rdata_p1_d;
  logic [DATA_W-1:0]   old_word, new_word;

  logic [DATA_W-1:0]   mem [DEPTH];

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == INIT) begin
      init_cnt_d = init_cnt_q + (ADDR_W + 1)'(1);
      if (init_cnt_q == LAST_ADDR) state_d = RUN;
    end
    ready_d = (state_d == RUN);
  end

  assign accept = en & ready_q;
  assign ready  = ready_q;

  // Stage p0: request latch
  always_comb begin
    vld_p0_d   = accept;
    wen_p0_d   = accept ? wen   : wen_p0_q;
    addr_p0_d  = accept ? addr  : addr_p0_q;
    wdata_p0_d = accept ? wdata : wdata_p0_q;
  end

  // Stage p1: array write and read capture; a request one cycle behind already sees this write
  always_comb begin
    old_word   = mem[addr_p0_q];
    new_word   = merge_bytes(old_word, wdata_p0_q, wen_p0_q);
    vld_p1_d   = vld_p0_q;
    rdata_p1_d = rdata_p1_q;
    if (vld_p0_q) rdata_p1_d = (WR_MODE != 0) ? new_word : old_word;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= RST_STATE;
      init_cnt_q <= '0;
      ready_q    <= 1'b0;
      vld_p0_q   <= 1'b0;
      vld_p1_q   <= 1'b0;
      rdata_p1_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      ready_q    <= ready_d;
      vld_p0_q   <= vld_p0_d;
      vld_p1_q   <= vld_p1_d;
      rdata_p1_q <= rdata_p1_d;
    end
  end

  always_ff @(posedge clk) begin
    wen_p0_q   <= wen_p0_d;
    addr_p0_q  <= addr_p0_d;
    wdata_p0_q <= wdata_p0_d;
  end

  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      mem[init_cnt_q[ADDR_W-1:0]] <= '0;
    end else if (vld_p0_q && (|wen_p0_q)) begin
      mem[addr_p0_q] <= new_word;
    end
  end

  // Stage p2: optional output register
  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic              vld_p2_q, vld_p2_d;
      logic [DATA_W-1:0] rdata_p2_q, rdata_p2_d;

      always_comb begin
        vld_p2_d   = vld_p1_q;
        rdata_p2_d = vld_p1_q ? rdata_p1_q : rdata_p2_q;
      end

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          vld_p2_q   <= 1'b0;
          rdata_p2_q <= '0;
        end else begin
          vld_p2_q   <= vld_p2_d;
          rdata_p2_q <= rdata_p2_d;
        end
      end

      assign rvalid = vld_p2_q;
      assign rdata  = rdata_p2_q;
    end else begin : g_no_out_reg
      assign rvalid = vld_p1_q;
      assign rdata  = rdata_p1_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_ram_pipe.sv
// Bench for sync_ram_pipe: four configurations run side by side against a request/response model,
// plus directed sequences with literal expected read data and latencies.
module tb_sync_ram_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  resetn;
  logic [3:0]  en;
  logic [7:0]  wen   [4];
  logic [9:0]  addr  [4];
  logic [63:0] wdata [4];

  logic rdy0, rdy1, rdy2, rdy3;
  logic rv0, rv1, rv2, rv3;
  logic [31:0] rd0, rd1, rd3;
  logic [63:0] rd2;
  logic [3:0]  rdy_v, rv_v;
  logic [63:0] rd_v [4];

  assign rdy_v = {rdy3, rdy2, rdy1, rdy0};
  assign rv_v  = {rv3, rv2, rv1, rv0};
  assign rd_v[0] = {32'h0, rd0};
  assign rd_v[1] = {32'h0, rd1};
  assign rd_v[2] = rd2;
  assign rd_v[3] = {32'h0, rd3};

  // 0: defaults  1: write-first  2: 64-bit with output register  3: no clear on reset
  sync_ram_pipe u_a (.clk(clk), .resetn(resetn[0]), .en(en[0]), .wen(wen[0][3:0]),
    .addr(addr[0][9:0]), .wdata(wdata[0][31:0]), .ready(rdy0), .rvalid(rv0), .rdata(rd0));
  sync_ram_pipe #(.ADDR_W(4), .WR_MODE(1)) u_b (.clk(clk), .resetn(resetn[1]), .en(en[1]),
    .wen(wen[1][3:0]), .addr(addr[1][3:0]), .wdata(wdata[1][31:0]), .ready(rdy1), .rvalid(rv1),
    .rdata(rd1));
  sync_ram_pipe #(.DATA_W(64), .ADDR_W(4), .OUT_REG(1)) u_c (.clk(clk), .resetn(resetn[2]),
    .en(en[2]), .wen(wen[2]), .addr(addr[2][3:0]), .wdata(wdata[2]), .ready(rdy2), .rvalid(rv2),
    .rdata(rd2));
  sync_ram_pipe #(.ADDR_W(4), .CLR_ON_RST(0)) u_d (.clk(clk), .resetn(resetn[3]), .en(en[3]),
    .wen(wen[3][3:0]), .addr(addr[3][3:0]), .wdata(wdata[3][31:0]), .ready(rdy3), .rvalid(rv3),
    .rdata(rd3));

  function automatic int cfg_aw(input int k);  return (k == 0) ? 10 : 4; endfunction
  function automatic int cfg_dw(input int k);  return (k == 2) ? 64 : 32; endfunction
  function automatic int cfg_or(input int k);  return (k == 2) ? 1 : 0; endfunction
  function automatic int cfg_wm(input int k);  return (k == 1) ? 1 : 0; endfunction
  function automatic int cfg_clr(input int k); return (k == 3) ? 0 : 1; endfunction

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  typedef struct { int e1; logic [7:0] be; logic [9:0] a; logic [63:0] d; } req_t;
  typedef struct { int due; logic [63:0] d; bit known; } rsp_t;

  req_t        rq [4][$];
  rsp_t        rs [4][$];
  logic [63:0] mm [4][1024];
  bit          mk [4][1024];
  logic [63:0] last_d [4];
  bit          last_k [4];
  int          since [4];
  int          acc_edge [4];
  int          rv_edge [4];
  int          rv_cnt [4];
  int          rise_edge [4];
  bit          prev_rdy [4];
  logic [63:0] got [4][$];
  int          edge_n = 0;

  task automatic step(input int k);
    logic [63:0] dm, old_w, mrg;
    logic [7:0]  bm;
    logic [9:0]  am;
    int          need;
    bit          rdy, ok, full, exp_v;
    req_t        r;
    rsp_t        p;
    dm   = (cfg_dw(k) == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    bm   = (cfg_dw(k) == 64) ? 8'hFF : 8'h0F;
    am   = 10'((1 << cfg_aw(k)) - 1);
    need = (cfg_clr(k) != 0) ? (1 << cfg_aw(k)) : 1;
    if (!resetn[k]) begin
      since[k] = 0;
      rq[k].delete();
      rs[k].delete();
      last_d[k] = '0;
      last_k[k] = 1'b1;
      if (cfg_clr(k) != 0) begin
        for (int a = 0; a < 1024; a++) begin mm[k][a] = '0; mk[k][a] = 1'b1; end
      end
      chk($sformatf("rst_ready[%0d]", k), {63'h0, rdy_v[k]}, 64'h0);
      chk($sformatf("rst_rvalid[%0d]", k), {63'h0, rv_v[k]}, 64'h0);
      chk($sformatf("rst_rdata[%0d]", k), rd_v[k], 64'h0);
      prev_rdy[k] = 1'b0;
      return;
    end
    rdy = (since[k] >= need);
    since[k]++;
    while (rq[k].size() > 0 && rq[k][0].e1 == edge_n) begin
      r     = rq[k].pop_front();
      old_w = mm[k][r.a];
      ok    = mk[k][r.a];
      full  = ((r.be & bm) == bm);
      mrg   = old_w;
      for (int b = 0; b < 8; b++) if (r.be[b]) mrg[b*8 +: 8] = r.d[b*8 +: 8];
      p.d     = (cfg_wm(k) != 0) ? mrg : old_w;
      p.known = (cfg_wm(k) != 0) ? (ok || full) : ok;
      p.due   = edge_n + cfg_or(k);
      rs[k].push_back(p);
      if ((r.be & bm) != 0) begin
        mm[k][r.a] = mrg;
        mk[k][r.a] = ok || full;
      end
    end
    if (en[k] && rdy) begin
      acc_edge[k] = edge_n;
      rq[k].push_back('{edge_n + 1, wen[k] & bm, addr[k] & am, wdata[k] & dm});
    end
    chk($sformatf("ready[%0d]@%0d", k, edge_n), {63'h0, rdy_v[k]},
        {63'h0, (since[k] >= need)});
    if (rdy_v[k] && !prev_rdy[k]) rise_edge[k] = since[k];
    prev_rdy[k] = rdy_v[k];
    exp_v = (rs[k].size() > 0 && rs[k][0].due == edge_n);
    chk($sformatf("rvalid[%0d]@%0d", k, edge_n), {63'h0, rv_v[k]}, {63'h0, exp_v});
    if (rv_v[k]) begin
      rv_cnt[k]++;
      rv_edge[k] = edge_n;
      got[k].push_back(rd_v[k]);
    end
    if (exp_v) begin
      p = rs[k].pop_front();
      if (p.known) chk($sformatf("rdata[%0d]@%0d", k, edge_n), rd_v[k], p.d);
      last_d[k] = p.d;
      last_k[k] = p.known;
    end else if (last_k[k]) begin
      chk($sformatf("rdata_hold[%0d]@%0d", k, edge_n), rd_v[k], last_d[k]);
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      last_k[k] = 1'b1; last_d[k] = '0; since[k] = 0; rv_cnt[k] = 0;
      acc_edge[k] = 0; rv_edge[k] = 0; rise_edge[k] = 0; prev_rdy[k] = 1'b0;
      for (int a = 0; a < 1024; a++) begin mm[k][a] = '0; mk[k][a] = 1'b0; end
    end
    forever begin
      @(posedge clk);
      edge_n++;
      #1;
      for (int k = 0; k < 4; k++) step(k);
    end
  end

  function automatic logic [63:0] gotv(input int k, input int i);
    if (i < got[k].size()) return got[k][i];
    return 64'hBAD0_BAD0_BAD0_BAD0;
  endfunction

  task automatic req(input int k, input logic [7:0] be, input logic [9:0] a, input logic [63:0] d);
    en[k] = 1'b1; wen[k] = be; addr[k] = a; wdata[k] = d;
    @(negedge clk);
    en[k] = 1'b0; wen[k] = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ready(input int k);
    int n = 0;
    while (rdy_v[k] !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    if (rdy_v[k] !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_ready[%0d]: ready %b after %0d cycles, required 1", k, rdy_v[k], n);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = '0;
    en     = '0;
    for (int k = 0; k < 4; k++) begin wen[k] = '0; addr[k] = '0; wdata[k] = '0; end
    @(negedge clk);
    repeat (3) @(negedge clk);
    resetn = 4'hF;

    // en held high while the write-first instance is still clearing its array
    en[1] = 1'b1; wen[1] = 8'h0F;
    for (int i = 0; i < 10; i++) begin
      addr[1] = 10'(i); wdata[1] = 64'hFFFF_0000 + 64'(i);
      @(negedge clk);
    end
    en[1] = 1'b0; wen[1] = '0;
    wait_ready(1);
    chk("b_rise_edge", 64'(rise_edge[1]), 64'd16);
    chk("b_init_no_rvalid", 64'(rv_cnt[1]), 64'd0);
    got[1].delete();
    req(1, 8'h00, 10'd9, '0);
    req(1, 8'h00, 10'd2, '0);
    idle(3);
    chk("b_init_clean_9", gotv(1, 0), 64'h0);
    chk("b_init_clean_2", gotv(1, 1), 64'h0);

    // 64-bit, output register: write then read the same address on the next cycle
    wait_ready(2);
    got[2].delete();
    req(2, 8'hFF, 10'd3, 64'h0123_4567_89AB_CDEF);
    req(2, 8'h00, 10'd3, '0);
    idle(5);
    chk("c_write_ack", gotv(2, 0), 64'h0);
    chk("c_read_hazard", gotv(2, 1), 64'h0123_4567_89AB_CDEF);
    chk("c_latency", 64'(rv_edge[2] - acc_edge[2]), 64'd2);
    chk("c_rvalid_count", 64'(rv_cnt[2]), 64'd2);

    // reset abort on the no-clear instance
    wait_ready(3);
    got[3].delete();
    req(3, 8'h0F, 10'd7, 64'hA5A5_A5A5);
    idle(3);
    en[3] = 1'b1; wen[3] = 8'h0F; addr[3] = 10'd7; wdata[3] = 64'h1234_5678;
    @(posedge clk);
    #2;
    resetn[3] = 1'b0;
    @(negedge clk);
    en[3] = 1'b0; wen[3] = '0;
    idle(3);
    resetn[3] = 1'b1;
    wait_ready(3);
    chk("d_abort_no_rvalid", 64'(rv_cnt[3]), 64'd1);
    req(3, 8'h00, 10'd7, '0);
    idle(3);
    chk("d_read_after_abort", gotv(3, 1), 64'hA5A5_A5A5);
    chk("d_rvalid_count", 64'(rv_cnt[3]), 64'd2);

    // write-first byte-enable sequence
    req(1, 8'h0F, 10'd5, 64'hDEAD_BEEF);
    req(1, 8'h05, 10'd5, 64'h1122_3344);
    idle(2);
    req(1, 8'h00, 10'd5, '0);
    idle(3);
    chk("b_wf_ack1", gotv(1, 2), 64'hDEAD_BEEF);
    chk("b_wf_ack2", gotv(1, 3), 64'hDE22_BE44);
    chk("b_wf_read", gotv(1, 4), 64'hDE22_BE44);

    // defaults: clear time, cleared reads, read-first sequence
    wait_ready(0);
    chk("a_rise_edge", 64'(rise_edge[0]), 64'd1024);
    got[0].delete();
    req(0, 8'h00, 10'h000, '0);
    req(0, 8'h00, 10'h3FF, '0);
    req(0, 8'h00, 10'h155, '0);
    idle(3);
    chk("a_read_000", gotv(0, 0), 64'h0);
    chk("a_read_3ff", gotv(0, 1), 64'h0);
    chk("a_read_155", gotv(0, 2), 64'h0);
    chk("a_latency", 64'(rv_edge[0] - acc_edge[0]), 64'd1);
    req(0, 8'h0F, 10'd5, 64'hDEAD_BEEF);
    req(0, 8'h05, 10'd5, 64'h1122_3344);
    idle(2);
    req(0, 8'h00, 10'd5, '0);
    idle(3);
    chk("a_rf_ack1", gotv(0, 3), 64'h0);
    chk("a_rf_ack2", gotv(0, 4), 64'hDEAD_BEEF);
    chk("a_rf_read", gotv(0, 5), 64'hDE22_BE44);
    chk("a_rvalid_count", 64'(rv_cnt[0]), 64'd6);

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
